// File: rtl/dfr_output_streamer.sv
// Drains the DFR core's output RAM as an AXI4-Stream master.
// Reads are throttled so a 2-entry FIFO plus one in-flight read never overflow.
//
// state  | meaning
// IDLE   | waiting for start; read port not owned
// STREAM | issuing reads, emitting beats
// DRAIN  | all reads issued, emitting remaining beats
module dfr_output_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_sent
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH-1:0] words_sent_q, words_sent_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic [ADDR_WIDTH-1:0] addr_now;
    logic [1:0]            occ;
    logic                  tvalid;
    logic                  tlast;
    logic                  pop;
    logic                  push;
    logic                  ren;
    logic                  final_hs;
    logic                  start_ok;
    logic                  start_zero;
    logic                  do_abort;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            num_q        <= '0;
            issue_cnt_q  <= '0;
            words_sent_q <= '0;
            mem_addr_q   <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            issue_cnt_q  <= issue_cnt_d;
            words_sent_q <= words_sent_d;
            mem_addr_q   <= mem_addr_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Output process: stream handshake and read-throttle decode.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        tvalid     = (count_q != 2'd0);
        tlast      = tvalid && (words_sent_q == (num_q - ADDR_WIDTH'(1)));
        pop        = tvalid && M_AXIS_TREADY;
        push       = inflight_q;
        final_hs   = pop && tlast;
        start_ok   = (state_q == ST_IDLE) && start && (num_words != '0);
        start_zero = (state_q == ST_IDLE) && start && (num_words == '0);
        do_abort   = busy && abort;
        occ        = count_q + {1'b0, inflight_q} - {1'b0, pop};
        addr_now   = base_q + issue_cnt_q;
        ren        = (state_q == ST_STREAM) && (issue_cnt_q != num_q) && (occ < 2'd2);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (abort || final_hs) state_d = ST_IDLE;
                else if (ren && ((issue_cnt_q + ADDR_WIDTH'(1)) == num_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort || final_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        base_d       = base_q;
        num_d        = num_q;
        issue_cnt_d  = issue_cnt_q;
        words_sent_d = words_sent_q;
        mem_addr_d   = mem_addr_q;
        inflight_d   = ren;
        done_d       = start_zero || (final_hs && !do_abort);
        fifo_d[0]    = fifo_q[0];
        fifo_d[1]    = fifo_q[1];
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};

        if (start_ok) begin
            base_d       = base_addr;
            num_d        = num_words;
            issue_cnt_d  = '0;
            words_sent_d = '0;
        end

        if (ren) begin
            issue_cnt_d = issue_cnt_q + ADDR_WIDTH'(1);
            mem_addr_d  = addr_now;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = mem_dout;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d     = ~rd_ptr_q;
            words_sent_d = words_sent_q + ADDR_WIDTH'(1);
        end

        // Abort discards buffered and in-flight data and beats a same-cycle handshake.
        if (do_abort) begin
            count_d      = '0;
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            inflight_d   = 1'b0;
            words_sent_d = words_sent_q;
        end
    end

    assign mem_ren       = ren;
    assign mem_addr      = ren ? addr_now : mem_addr_q;
    assign M_AXIS_TDATA  = fifo_q[rd_ptr_q];
    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TLAST  = tlast;
    assign done          = done_q;
    assign words_sent    = words_sent_q;

endmodule

// File: tb/tb_dfr_output_streamer.sv
// Bench for dfr_output_streamer: behavioural RAM plus a queue-based model of
// the expected word order, addresses, counts and timing.
module tb_dfr_output_streamer;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_words;
    logic [AW-1:0] mem_addr;
    logic          mem_ren;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          busy;
    logic          done;
    logic [AW-1:0] words_sent;

    logic [DW-1:0] ram [0:DEPTH-1];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_ren) mem_dout <= ram[mem_addr];

    dfr_output_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .mem_addr      (mem_addr),
        .mem_ren       (mem_ren),
        .mem_dout      (mem_dout),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .M_AXIS_TLAST  (tlast),
        .busy          (busy),
        .done          (done),
        .words_sent    (words_sent)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ren"}, mem_ren, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_ws"}, words_sent, 0);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_addr"}, mem_addr, 0);
    endtask

    // rmode: 0 ready high, 1 pattern 1,0,0, 2 random, 3 long stall then random
    // act:   0 none, 1 abort after act_k handshakes, 2 reset after act_k handshakes
    task automatic run_xfer(input logic [AW-1:0] base, input int n, input int rmode,
                            input int act, input int act_k, input bit inject);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] prev_data = '0;
        int  reads = 0;
        int  hs = 0;
        int  cyc = 0;
        int  first_v = -1;
        int  last_cyc = -1;
        bit  stalled = 0;
        bit  fin = 0;
        bit  prev_valid = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(ram[(int'(base) + i) % DEPTH]);

        @(negedge clk);
        base_addr = base;
        num_words = AW'(n);
        start = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (!fin && cyc < 4 * n + 40) begin
            if (cyc != 0) @(negedge clk);
            cyc++;
            case (rmode)
                0: tready = 1'b1;
                1: tready = ((cyc % 3) == 1);
                2: tready = 1'($urandom_range(0, 1));
                default: tready = (cyc < 12) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
            if (inject && cyc == 4) begin
                start = 1'b1;
                base_addr = AW'($urandom);
                num_words = AW'($urandom);
            end else begin
                start = 1'b0;
            end

            if (act == 1 && hs == act_k) begin
                abort = 1'b1;
                tready = 1'b1;
                #1;
                check("abort_ws_cycle", words_sent, act_k);
                @(negedge clk);
                abort = 1'b0;
                #1;
                check("abort_tvalid", tvalid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_ws", words_sent, act_k);
                @(negedge clk);
                #1;
                check("abort_done2", done, 0);
                check("abort_tvalid2", tvalid, 0);
                return;
            end

            if (act == 2 && hs == act_k) begin
                check("rst_prev_valid", prev_valid, 1);
                rst_n = 1'b0;
                #1;
                check_idle_zero("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check_idle_zero("postrst");
                return;
            end

            #1;
            check("busy", busy, 1);
            check("done_low", done, 0);
            check("words_sent", words_sent, hs);
            if (stalled) begin
                check("stall_valid", tvalid, 1);
                check("stall_data", tdata, prev_data);
            end
            if (rmode == 0 && cyc == 1) check("first_read", mem_ren, 1);
            if (mem_ren) begin
                check("rd_addr", mem_addr, (int'(base) + reads) % DEPTH);
                check("rd_budget", reads < n, 1);
                reads++;
            end
            if (tvalid) begin
                if (first_v < 0) first_v = cyc;
                check("tlast", tlast, hs == n - 1);
            end
            if (tvalid && tready) begin
                if (hs < n) check("tdata", tdata, exp_q[hs]);
                hs++;
                if (hs == n) begin
                    fin = 1;
                    last_cyc = cyc;
                end
            end
            check("outstanding", (reads - hs) <= 3, 1);
            stalled = tvalid && !tready;
            prev_valid = tvalid;
            prev_data = tdata;
        end

        check("finished", fin, 1);
        @(negedge clk);
        tready = 1'b1;
        #1;
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        check("end_tvalid", tvalid, 0);
        check("end_ws", words_sent, n);
        check("end_reads", reads, n);
        if (rmode == 0) begin
            check("latency_first_valid", first_v, 3);
            check("latency_final", last_cyc, n + 2);
        end
        @(negedge clk);
        #1;
        check("done_pulse", done, 0);
        check("ws_hold", words_sent, n);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tready = 1'b0;
        base_addr = '0;
        num_words = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        for (int i = 0; i < 16; i++) ram[i] = 32'h100 + i;

        repeat (3) @(negedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer(14'h0000, 5, 0, 0, 0, 0);
        run_xfer(14'h0000, 5, 1, 0, 0, 0);
        run_xfer(14'h3FFE, 4, 0, 0, 0, 0);
        run_xfer(14'h0007, 1, 0, 0, 0, 0);

        // zero-length start: done only
        @(negedge clk);
        base_addr = 14'd5;
        num_words = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_ren", mem_ren, 0);
        check("zero_tvalid", tvalid, 0);
        @(negedge clk);
        #1;
        check("zero_done2", done, 0);
        check("zero_busy2", busy, 0);
        check("zero_ren2", mem_ren, 0);
        check("zero_tvalid2", tvalid, 0);

        run_xfer(AW'($urandom), 10, 0, 1, 3, 0);
        run_xfer(14'h0020, 10, 0, 0, 0, 0);

        run_xfer(14'h0100, 10, 0, 2, 2, 0);
        run_xfer(14'h0040, 6, 0, 0, 0, 0);

        for (int t = 0; t < 6; t++)
            run_xfer(AW'($urandom), $urandom_range(1, 20), 2 + (t % 2), 0, 0, 1'(t % 2));

        // abort while idle does nothing
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("idle_abort_busy", busy, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("idle_abort_busy2", busy, 0);
        check("idle_abort_done", done, 0);

        // start and abort together in idle: start wins
        base_addr = 14'h0003;
        num_words = 14'd3;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_wins_busy", busy, 1);
        check("start_wins_ws", words_sent, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("start_wins_abort_busy", busy, 0);

        run_xfer(14'h0003, 3, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
